// File: rtl/pwm_output_stage.sv
// PWM output stage: 16 pins, each held low, held high or driven by a shared 8-bit PWM level.
// Optional macro PWM_SHADOW_EN latches the duty value only at period boundaries.
module pwm_output_stage #(
    parameter int unsigned PRESCALE   = 13,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [PRESCALE_W-1:0] PreMax = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]            pwm_cnt_q, pwm_cnt_d;
    logic [15:0]           out_q, out_d;
    logic                  period_start_q, period_start_d;
    logic                  tick;
    logic                  wrap;
    logic [7:0]            duty_active;
    logic                  pwm_level;
    logic [15:0]           en_out;
    logic [15:0]           en_pwm;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    assign tick = (pre_cnt_q == PreMax);
    // Last count step of the period: pwm_cnt rolls 255 -> 0 on this edge.
    assign wrap = tick && (pwm_cnt_q == 8'hFF);

`ifdef PWM_SHADOW_EN
    logic [7:0] duty_q, duty_d;

    always_comb begin
        duty_d = duty_q;
        if (wrap) begin
            duty_d = pwm_duty_cycle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q <= 8'h00;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_active = duty_q;
`else
    assign duty_active = pwm_duty_cycle;
`endif

    // 0xFF must stay high through count 255, which a plain compare would drop.
    assign pwm_level = (duty_active == 8'hFF) || (pwm_cnt_q < duty_active);

    always_comb begin
        pre_cnt_d      = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        period_start_d = wrap;
        out_d          = en_out & (~en_pwm | {16{pwm_level}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= 8'h00;
            period_start_q <= 1'b0;
            out_q          <= 16'h0000;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            period_start_q <= period_start_d;
            out_q          <= out_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Scoreboard bench for pwm_output_stage: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against out / period_start.
module tb_pwm_output_stage;

    localparam int PRE = 13;
`ifdef PWM_SHADOW_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  en_reg_out_7_0 = 8'h00;
    logic [7:0]  en_reg_out_15_8 = 8'h00;
    logic [7:0]  en_reg_pwm_7_0 = 8'h00;
    logic [7:0]  en_reg_pwm_15_8 = 8'h00;
    logic [7:0]  pwm_duty_cycle = 8'h00;
    logic [15:0] out;
    logic        period_start;

    pwm_output_stage #(
        .PRESCALE   (PRE),
        .PRESCALE_W (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    // cyc = number of posedges so far; stable when sampled at negedge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        bit          is_ps;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input int c, input bit is_ps, input logic [15:0] v, input string nm);
        exp_t e;
        int   i;
        e.cyc   = c;
        e.is_ps = is_ps;
        e.val   = v;
        e.name  = nm;
        i = 0;
        while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
        exp_q.insert(i, e);
    endtask

    task automatic exp_out(input int c, input logic [15:0] v, input string nm);
        push_exp(c, 1'b0, v, nm);
    endtask

    task automatic exp_ps(input int c, input logic v, input string nm);
        push_exp(c, 1'b1, {15'd0, v}, nm);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            cur = exp_q.pop_front();
            checks++;
            if (cur.cyc != cyc) begin
                errors++;
                $display("FAIL %s: check for cycle %0d missed (now cycle %0d)",
                         cur.name, cur.cyc, cyc);
            end else if (cur.is_ps) begin
                if (period_start !== cur.val[0]) begin
                    errors++;
                    $display("FAIL %s @%0d: period_start got %b expected %b",
                             cur.name, cyc, period_start, cur.val[0]);
                end
            end else if (out !== cur.val) begin
                errors++;
                $display("FAIL %s @%0d: out got %h expected %h", cur.name, cyc, out, cur.val);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_regs(input logic [7:0] eo_lo, input logic [7:0] eo_hi,
                            input logic [7:0] ep_lo, input logic [7:0] ep_hi,
                            input logic [7:0] duty);
        en_reg_out_7_0  = eo_lo;
        en_reg_out_15_8 = eo_hi;
        en_reg_pwm_7_0  = ep_lo;
        en_reg_pwm_15_8 = ep_hi;
        pwm_duty_cycle  = duty;
    endtask

    // Called at a negedge; one reset edge, returns that edge's cycle number.
    task automatic do_reset(output int r);
        r = cyc + 1;
        exp_out(r, 16'h0000, "rst_out");
        exp_ps(r, 1'b0, "rst_ps");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int r;
    int r2;
    int c;

    initial begin
        // 1: two-cycle reset with everything enabled, duty 0x80
        set_regs(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80);
        rst = 1'b1;
        exp_out(1, 16'h0000, "t1_rst_out_c1");
        exp_ps(1, 1'b0, "t1_rst_ps_c1");
        exp_out(2, 16'h0000, "t1_rst_out_c2");
        exp_ps(2, 1'b0, "t1_rst_ps_c2");
        r = 2;
        exp_out(r + 1, SH ? 16'h0000 : 16'hFFFF, "t1_first_out");
        exp_out(r + 1664, SH ? 16'h0000 : 16'hFFFF, "t1_last_high");
        exp_out(r + 1665, 16'h0000, "t1_first_low");
        exp_ps(r + 1, 1'b0, "t1_no_ps_on_release");
        exp_ps(r + 3327, 1'b0, "t1_ps_early");
        exp_ps(r + 3328, 1'b1, "t1_ps_first");
        exp_ps(r + 3329, 1'b0, "t1_ps_one_cycle");
        exp_out(r + 3329, 16'hFFFF, "t1_period2_high");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_until(r + 3330);

        // 2: static mode and enable gating
        set_regs(8'h00, 8'h00, 8'h00, 8'h00, 8'h80);
        do_reset(r);
        c = r + 5;
        exp_out(c, 16'h0000, "t2_all_off");
        exp_out(c + 1, 16'h0001, "t2_static_pin0");
        exp_out(c + 3, 16'h0001, "t2_pwm_without_en");
        exp_out(c + 5, SH ? 16'h0001 : 16'h0003, "t2_pwm_pin1");
        exp_out(c + 7, SH ? 16'h8001 : 16'h8003, "t2_static_pin15");
        wait_until(c);
        en_reg_out_7_0 = 8'h01;
        wait_until(c + 2);
        en_reg_pwm_7_0 = 8'h02;
        wait_until(c + 4);
        en_reg_out_7_0 = 8'h03;
        wait_until(c + 6);
        en_reg_out_15_8 = 8'h80;
        wait_until(c + 8);

        // 3: 50% duty on pins 0 and 8
        set_regs(8'h01, 8'h01, 8'h01, 8'h01, 8'h80);
        do_reset(r);
        exp_out(r + 1, SH ? 16'h0000 : 16'h0101, "t3_p1_rise");
        exp_out(r + 1664, SH ? 16'h0000 : 16'h0101, "t3_p1_last_high");
        exp_out(r + 1665, 16'h0000, "t3_p1_fall");
        exp_out(r + 3328, 16'h0000, "t3_p1_last_low");
        exp_ps(r + 3327, 1'b0, "t3_ps_early");
        exp_ps(r + 3328, 1'b1, "t3_ps");
        exp_out(r + 3329, 16'h0101, "t3_p2_rise");
        exp_out(r + 4992, 16'h0101, "t3_p2_last_high");
        exp_out(r + 4993, 16'h0000, "t3_p2_fall");
        wait_until(r + 4994);

        // 4a: duty 0x00 stays low for two periods
        set_regs(8'h01, 8'h01, 8'h01, 8'h01, 8'h00);
        do_reset(r);
        exp_out(r + 1, 16'h0000, "t4_zero_a");
        exp_out(r + 1664, 16'h0000, "t4_zero_b");
        exp_out(r + 3328, 16'h0000, "t4_zero_c");
        exp_out(r + 3329, 16'h0000, "t4_zero_d");
        exp_out(r + 6656, 16'h0000, "t4_zero_e");
        exp_out(r + 6657, 16'h0000, "t4_zero_f");
        wait_until(r + 6658);

        // 4b: duty 0xFF stays high, including count 255 and the wrap
        pwm_duty_cycle = 8'hFF;
        do_reset(r);
        exp_out(r + 1, SH ? 16'h0000 : 16'h0101, "t4_full_start");
        exp_out(r + 3328, SH ? 16'h0000 : 16'h0101, "t4_full_cnt255");
        exp_out(r + 3329, 16'h0101, "t4_full_wrap");
        exp_out(r + 3330, 16'h0101, "t4_full_after_wrap");
        exp_out(r + 6656, 16'h0101, "t4_full_cnt255_p2");
        exp_out(r + 6657, 16'h0101, "t4_full_wrap_p2");
        wait_until(r + 6658);

        // 5: duty 0x40 -> 0xC0 at pwm_cnt 0x20 of period 2, then a brief dip to 0x40
        pwm_duty_cycle = 8'h40;
        do_reset(r);
        exp_out(r + 4160, 16'h0101, "t5_p2_high_832");
        exp_out(r + 4161, SH ? 16'h0000 : 16'h0101, "t5_p2_after_832");
        exp_out(r + 5824, SH ? 16'h0000 : 16'h0101, "t5_p2_at_2496");
        exp_out(r + 5825, 16'h0000, "t5_p2_after_2496");
        exp_out(r + 8320, 16'h0101, "t5_p3_before_dip");
        exp_out(r + 8321, SH ? 16'h0101 : 16'h0000, "t5_p3_dip");
        exp_out(r + 8322, 16'h0101, "t5_p3_return_high");
        exp_out(r + 9152, 16'h0101, "t5_p3_high_2496");
        exp_out(r + 9153, 16'h0000, "t5_p3_fall");
        wait_until(r + 3744);
        pwm_duty_cycle = 8'hC0;
        wait_until(r + 8320);
        pwm_duty_cycle = 8'h40;
        wait_until(r + 8321);
        pwm_duty_cycle = 8'hC0;
        wait_until(r + 9154);

        // 6: reset at pwm_cnt 0x90 with duty 0xC0, then a clean restart
        pwm_duty_cycle = 8'hC0;
        do_reset(r);
        exp_out(r + 1872, SH ? 16'h0000 : 16'h0101, "t6_before_mid_rst");
        wait_until(r + 1872);
        do_reset(r2);
        exp_out(r2 + 1, SH ? 16'h0000 : 16'h0101, "t6_restart");
        exp_out(r2 + 2496, SH ? 16'h0000 : 16'h0101, "t6_last_high");
        exp_out(r2 + 2497, 16'h0000, "t6_fall");
        exp_ps(r2 + 3327, 1'b0, "t6_ps_early");
        exp_ps(r2 + 3328, 1'b1, "t6_ps");
        exp_out(r2 + 3329, 16'h0101, "t6_p2_rise");
        exp_out(r2 + 5824, 16'h0101, "t6_p2_last_high");
        exp_out(r2 + 5825, 16'h0000, "t6_p2_fall");
        wait_until(r2 + 5826);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked, expected 0", exp_q.size());
            errors += exp_q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
